// File: rtl/config_frame_writer_pkg.sv
// Shared fabric configuration definitions: header layout, sync byte and the
// frame writer state encoding.
package config_frame_writer_pkg;

  // Sync byte that marks a valid frame write header
  localparam logic [7:0] CFG_SYNC_BYTE = 8'hA5;

  // Header field positions
  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_IDX_MSB  = 4;
  localparam int HDR_IDX_LSB  = 0;
  localparam int HDR_IDX_W    = HDR_IDX_MSB - HDR_IDX_LSB + 1;

  // Strobe duration counter width (holds up to 15 cycles)
  localparam int STROBE_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } cfg_state_t;

endpackage

// File: rtl/config_frame_writer_strobe_timer.sv
// Strobe duration timer: loaded with the strobe length, counts down once per
// strobe cycle and flags the final strobe cycle.
module strobe_timer
  import config_frame_writer_pkg::*;
#(
  parameter int StrobeCycles = 2
) (
  input  logic CLK,
  input  logic resetn,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [STROBE_CNT_W-1:0] count;

  // Load the strobe length on entry to STROBE, decrement on each strobe cycle
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= STROBE_CNT_W'(StrobeCycles);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The cycle holding a count of one is the last strobe cycle
  assign done = (count == STROBE_CNT_W'(1));

endmodule

// File: rtl/config_frame_writer.sv
// Configuration frame writer: accepts a header word (sync + frame index) and a
// data word, then drives the row data and a timed one-hot frame strobe.
module config_frame_writer
  import config_frame_writer_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] WriteData,
  input  logic                       WriteValid,
  output logic                       WriteReady,
  input  logic                       ErrClear,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       FrameDone,
  output logic                       Error
);

  localparam logic [HDR_IDX_W:0]       FRAME_LIMIT = (HDR_IDX_W + 1)'(MaxFramesPerCol);
  localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

  cfg_state_t           state;
  logic [HDR_IDX_W-1:0] frame_idx;
  logic [7:0]           hdr_sync;
  logic [HDR_IDX_W-1:0] hdr_idx;
  logic                 xfer;
  logic                 hdr_ok;
  logic                 err_event;
  logic                 timer_load;
  logic                 timer_tick;
  logic                 timer_done;

  assign hdr_sync   = WriteData[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_idx    = WriteData[HDR_IDX_MSB:HDR_IDX_LSB];
  assign xfer       = WriteValid & WriteReady;
  assign hdr_ok     = (hdr_sync == CFG_SYNC_BYTE) && ({1'b0, hdr_idx} < FRAME_LIMIT);
  // A rejected header is consumed in IDLE and raises the error flag
  assign err_event  = xfer && (state == ST_IDLE) && !hdr_ok;
  assign timer_load = (state == ST_SETUP);
  assign timer_tick = (state == ST_STROBE);

  strobe_timer #(
    .StrobeCycles(StrobeCycles)
  ) u_strobe_timer (
    .CLK   (CLK),
    .resetn(resetn),
    .load  (timer_load),
    .tick  (timer_tick),
    .done  (timer_done)
  );

  // Frame write sequencer with registered ready, data, strobe and done outputs
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      frame_idx   <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      FrameDone   <= 1'b0;
      WriteReady  <= 1'b0;
    end else begin
      FrameDone <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Ready may still be low on the first edge after reset release
          WriteReady <= 1'b1;
          if (xfer && hdr_ok) begin
            frame_idx <= hdr_idx;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            FrameData  <= WriteData;
            WriteReady <= 1'b0;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Data has settled for one cycle; raise the selected strobe
          FrameStrobe <= STROBE_ONE << frame_idx;
          state       <= ST_STROBE;
        end
        ST_STROBE: begin
          if (timer_done) begin
            FrameStrobe <= '0;
            FrameDone   <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          WriteReady <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          FrameStrobe <= '0;
          WriteReady  <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      Error <= 1'b0;
    end else if (err_event) begin
      Error <= 1'b1;
    end else if (ErrClear) begin
      Error <= 1'b0;
    end
  end

endmodule
